vector_checker: RTL and testbench

VECTOR_CHECKER -- requirements
Module: vector_checker

---
 rtl/vector_checker.sv | 161 ++++++++++++++++
 tb/tb_vector_checker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_checker.sv
// vector_checker: scoreboard for a 3-input/2-output block under test.
// The stimulus side pushes {vec, golden yz} pairs into a small FIFO; each DUT
// response pops the oldest pair and is compared against its golden value.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start, num_vecs   begin a run of num_vecs responses (ignored while busy)
//   exp_valid/ready   expected-entry handshake; exp_vec = {a,b,c}, exp_yz = {y,z}
//   resp_valid/yz     response from the block under test
//   busy, done        run in progress / run finished
//   pass_cnt/fail_cnt saturating match / mismatch counts
//   first_fail_*      stimulus of the first mismatch of the run
//   orphan            sticky: a response arrived with no expected entry queued
//
// Optional feature: define VECTOR_CHECKER_STOP_ON_FAIL_EN to end the run on
// the first mismatch.
module vector_checker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vecs,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [2:0]       exp_vec,
  input  logic [1:0]       exp_yz,
  input  logic             resp_valid,
  input  logic [1:0]       resp_yz,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_valid,
  output logic [2:0]       first_fail_vec,
  output logic             orphan
);

  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic             r_ff_valid;
  logic [2:0]       r_ff_vec;
  logic             r_orphan;
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic [4:0]       r_mem [DEPTH];

  logic             w_run;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [4:0]       w_head;
  logic             w_match;
  logic [CNT_W:0]   w_total;
  logic             w_last;
  logic             w_stop;
  logic [CNT_W-1:0] w_pass_inc;
  logic [CNT_W-1:0] w_fail_inc;

  assign w_run   = (r_state == S_RUN);
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  // Full blocks pushes even when a pop frees a slot this cycle.
  assign w_push  = exp_valid && exp_ready;
  assign w_pop   = w_run && resp_valid && !w_empty;
  assign w_head  = r_mem[r_rptr[PW-1:0]];
  assign w_match = (resp_yz == w_head[1:0]);

  // Responses counted including the one being scored this cycle.
  assign w_total = {1'b0, r_pass} + {1'b0, r_fail} + (CNT_W + 1)'(1);
  assign w_last  = (w_total >= {1'b0, r_num});

  assign w_pass_inc = (r_pass == '1) ? r_pass : r_pass + CNT_W'(1);
  assign w_fail_inc = (r_fail == '1) ? r_fail : r_fail + CNT_W'(1);

`ifdef VECTOR_CHECKER_STOP_ON_FAIL_EN
  assign w_stop = w_pop && !w_match && !r_ff_valid;
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[PW-1:0]] <= {exp_vec, exp_yz};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_num      <= '0;
      r_pass     <= '0;
      r_fail     <= '0;
      r_ff_valid <= 1'b0;
      r_ff_vec   <= '0;
      r_orphan   <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_num      <= num_vecs;
            r_pass     <= '0;
            r_fail     <= '0;
            r_ff_valid <= 1'b0;
            r_ff_vec   <= '0;
            r_orphan   <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_state    <= (num_vecs == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_push) begin
            r_wptr <= r_wptr + (PW + 1)'(1);
          end
          if (w_pop) begin
            r_rptr <= r_rptr + (PW + 1)'(1);
            if (w_match) begin
              r_pass <= w_pass_inc;
            end else begin
              r_fail <= w_fail_inc;
              if (!r_ff_valid) begin
                r_ff_valid <= 1'b1;
                r_ff_vec   <= w_head[4:2];
              end
            end
            if (w_last || w_stop) begin
              r_state <= S_DONE;
            end
          end else if (resp_valid && w_empty) begin
            r_orphan <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign exp_ready        = w_run && !w_full;
  assign busy             = w_run;
  assign done             = (r_state == S_DONE);
  assign pass_cnt         = r_pass;
  assign fail_cnt         = r_fail;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_vec   = r_ff_vec;
  assign orphan           = r_orphan;

endmodule

// File: tb/tb_vector_checker.sv
// Directed bench for vector_checker (DEPTH=4, CNT_W=8).
// Golden {y,z} for {a,b,c}: y = a^b^c, z = (a&b)|c, tabulated by hand below.
module tb_vector_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] num_vecs = '0;
  logic       exp_valid = 1'b0;
  logic       exp_ready;
  logic [2:0] exp_vec = '0;
  logic [1:0] exp_yz = '0;
  logic       resp_valid = 1'b0;
  logic [1:0] resp_yz = '0;
  logic       busy, done;
  logic [7:0] pass_cnt, fail_cnt;
  logic       first_fail_valid;
  logic [2:0] first_fail_vec;
  logic       orphan;

  int n_vec  = 0;
  int n_miss = 0;

  logic [1:0] gold [8];
  logic [2:0] ord  [8];

  vector_checker #(.DEPTH(4), .CNT_W(8)) u_dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .num_vecs         (num_vecs),
    .exp_valid        (exp_valid),
    .exp_ready        (exp_ready),
    .exp_vec          (exp_vec),
    .exp_yz           (exp_yz),
    .resp_valid       (resp_valid),
    .resp_yz          (resp_yz),
    .busy             (busy),
    .done             (done),
    .pass_cnt         (pass_cnt),
    .fail_cnt         (fail_cnt),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec),
    .orphan           (orphan)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".exp_ready"}, 32'(exp_ready), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".pass"}, 32'(pass_cnt), 0);
    check({tag, ".fail"}, 32'(fail_cnt), 0);
    check({tag, ".ffv"}, 32'(first_fail_valid), 0);
    check({tag, ".ffvec"}, 32'(first_fail_vec), 0);
    check({tag, ".orphan"}, 32'(orphan), 0);
  endtask

  task automatic start_run(input logic [7:0] n);
    start = 1'b1;
    num_vecs = n;
    tick();
    start = 1'b0;
  endtask

  // Push one expected entry, then return one response for it.
  task automatic push_resp(input logic [2:0] v, input logic [1:0] r);
    exp_valid = 1'b1;
    exp_vec = v;
    exp_yz = gold[v];
    tick();
    exp_valid = 1'b0;
    resp_valid = 1'b1;
    resp_yz = r;
    tick();
    resp_valid = 1'b0;
  endtask

  initial begin
    gold[0] = 2'b00; gold[1] = 2'b11; gold[2] = 2'b10; gold[3] = 2'b01;
    gold[4] = 2'b10; gold[5] = 2'b01; gold[6] = 2'b01; gold[7] = 2'b11;
    ord[0] = 3'd1; ord[1] = 3'd2; ord[2] = 3'd3; ord[3] = 3'd4;
    ord[4] = 3'd5; ord[5] = 3'd6; ord[6] = 3'd7; ord[7] = 3'd0;

    tick();
    tick();
    reset = 1'b0;
    check_reset_vals("reset");

    // All 8 combinations, all matching.
    start_run(8'd8);
    check("run1.busy", 32'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      push_resp(ord[i], gold[ord[i]]);
      check("run1.pass_step", 32'(pass_cnt), 32'(i + 1));
    end
    check("run1.done", 32'(done), 1);
    check("run1.busy_end", 32'(busy), 0);
    check("run1.fail", 32'(fail_cnt), 0);
    check("run1.ffv", 32'(first_fail_valid), 0);

    // Fourth response (vector 3'b100) has y inverted.
    start_run(8'd8);
    check("run2.restart_pass", 32'(pass_cnt), 0);
    for (int i = 0; i < 8; i++) begin
      push_resp(ord[i], (i == 3) ? (gold[ord[i]] ^ 2'b10) : gold[ord[i]]);
      if (i == 3) begin
        check("run2.fail_at4", 32'(fail_cnt), 1);
        check("run2.ffvec_at4", 32'(first_fail_vec), 4);
`ifdef VECTOR_CHECKER_STOP_ON_FAIL_EN
        check("run2.done_at4", 32'(done), 1);
`else
        check("run2.busy_at4", 32'(busy), 1);
`endif
      end
    end
    check("run2.done", 32'(done), 1);
    check("run2.fail", 32'(fail_cnt), 1);
    check("run2.ffv", 32'(first_fail_valid), 1);
    check("run2.ffvec", 32'(first_fail_vec), 4);
`ifdef VECTOR_CHECKER_STOP_ON_FAIL_EN
    check("run2.pass", 32'(pass_cnt), 3);
`else
    check("run2.pass", 32'(pass_cnt), 7);
`endif

    // Fill the 4-deep FIFO, offer a fifth entry, then pop one.
    start_run(8'd8);
    exp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_vec = ord[i];
      exp_yz = gold[ord[i]];
      check("fill.ready", 32'(exp_ready), 1);
      tick();
    end
    exp_vec = ord[4];
    exp_yz = gold[ord[4]];
    check("full.ready", 32'(exp_ready), 0);
    resp_valid = 1'b1;
    resp_yz = gold[ord[0]];
    tick();
    resp_valid = 1'b0;
    check("after_pop.ready", 32'(exp_ready), 1);
    check("after_pop.pass", 32'(pass_cnt), 1);
    tick();
    exp_valid = 1'b0;
    // Drain; order must be ord[1..4] for every response to match.
    resp_valid = 1'b1;
    for (int i = 1; i < 5; i++) begin
      resp_yz = gold[ord[i]];
      tick();
    end
    check("drain.pass", 32'(pass_cnt), 5);
    check("drain.fail", 32'(fail_cnt), 0);

    // FIFO now empty: response is an orphan.
    resp_yz = 2'b00;
    tick();
    resp_valid = 1'b0;
    check("orphan.flag", 32'(orphan), 1);
    check("orphan.pass", 32'(pass_cnt), 5);
    check("orphan.fail", 32'(fail_cnt), 0);

    // start while running is ignored.
    start_run(8'd1);
    check("start_in_run.busy", 32'(busy), 1);
    check("start_in_run.orphan", 32'(orphan), 1);

    // Reset after 3 of 8 responses, asserted together with start.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start_run(8'd8);
    for (int i = 0; i < 3; i++) push_resp(ord[i], gold[ord[i]]);
    check("mid.pass", 32'(pass_cnt), 3);
    reset = 1'b1;
    start = 1'b1;
    num_vecs = 8'd8;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check_reset_vals("midreset");

    // Two-vector run with a simultaneous push and pop.
    start_run(8'd2);
    exp_valid = 1'b1;
    exp_vec = ord[0];
    exp_yz = gold[ord[0]];
    tick();
    exp_vec = ord[1];
    exp_yz = gold[ord[1]];
    resp_valid = 1'b1;
    resp_yz = gold[ord[0]];
    tick();
    exp_valid = 1'b0;
    resp_yz = gold[ord[1]];
    tick();
    resp_valid = 1'b0;
    check("run2v.pass", 32'(pass_cnt), 2);
    check("run2v.fail", 32'(fail_cnt), 0);
    check("run2v.done", 32'(done), 1);

    // num_vecs = 0 goes straight to DONE; responses there are ignored.
    start_run(8'd0);
    check("zero.done", 32'(done), 1);
    check("zero.busy", 32'(busy), 0);
    check("zero.pass", 32'(pass_cnt), 0);
    resp_valid = 1'b1;
    resp_yz = 2'b11;
    tick();
    resp_valid = 1'b0;
    check("done_resp.pass", 32'(pass_cnt), 0);
    check("done_resp.orphan", 32'(orphan), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
